// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire temperature poller:
// engine opcodes, DS18B20 command bytes and the poll FSM state type.
package onewire_pkg;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    localparam logic [7:0] ROM_SKIP   = 8'hCC;
    localparam logic [7:0] FN_CONVERT = 8'h44;
    localparam logic [7:0] FN_READ_SP = 8'hBE;

    localparam int TIMER_W = 20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST1,
        ST_SKIP1,
        ST_CONV,
        ST_WAITC,
        ST_RST2,
        ST_SKIP2,
        ST_RDSP,
        ST_RDLO,
        ST_RDHI,
        ST_DONE
    } state_t;

    typedef enum logic {
        PH_ISSUE,
        PH_AWAIT
    } phase_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] data;
    } cmd_t;

    function automatic logic is_cmd_step(state_t s);
        return !(s inside {ST_IDLE, ST_WAITC, ST_DONE});
    endfunction

    function automatic logic is_reset_step(state_t s);
        return s inside {ST_RST1, ST_RST2};
    endfunction

    function automatic cmd_t step_cmd(state_t s);
        cmd_t c;
        c.op   = OP_RESET;
        c.data = 8'h00;
        case (s)
            ST_SKIP1, ST_SKIP2: begin
                c.op   = OP_WRITE;
                c.data = ROM_SKIP;
            end
            ST_CONV: begin
                c.op   = OP_WRITE;
                c.data = FN_CONVERT;
            end
            ST_RDSP: begin
                c.op   = OP_WRITE;
                c.data = FN_READ_SP;
            end
            ST_RDLO, ST_RDHI: c.op = OP_READ;
            default: ;
        endcase
        return c;
    endfunction

    function automatic state_t next_step(state_t s);
        case (s)
            ST_RST1:  return ST_SKIP1;
            ST_SKIP1: return ST_CONV;
            ST_CONV:  return ST_WAITC;
            ST_RST2:  return ST_SKIP2;
            ST_SKIP2: return ST_RDSP;
            ST_RDSP:  return ST_RDLO;
            ST_RDLO:  return ST_RDHI;
            ST_RDHI:  return ST_DONE;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/us_down_timer.sv
// Saturating down-counter in microsecond ticks with load and zero flag.
// Load wins over a coincident tick.
module us_down_timer
    import onewire_pkg::*;
(
    input  logic               clk,
    input  logic               nReset,
    input  logic               en,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && count_q != '0) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/temp_poll_scheduler.sv
// Sequences a DS18B20 conversion and scratchpad read through a
// 1-Wire byte engine, manually or on a periodic timer.
module temp_poll_scheduler
    import onewire_pkg::*;
#(
    parameter int CONV_WAIT_US   = 750000,
    parameter int POLL_PERIOD_US = 1000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        clk_en,
    input  logic        start,
    input  logic        auto_en,
    output logic        eng_cmd_valid,
    output logic [1:0]  eng_cmd_op,
    output logic [7:0]  eng_cmd_data,
    input  logic        eng_cmd_ready,
    input  logic        eng_rsp_valid,
    input  logic [7:0]  eng_rsp_data,
    input  logic        eng_rsp_presence,
    output logic [11:0] temp_data,
    output logic        temp_valid,
    output logic        busy,
    output logic        err_nopresence
);

    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);
    localparam logic [TIMER_W-1:0] CONV_LOAD = TIMER_W'(CONV_WAIT_US);
    localparam logic [TIMER_W-1:0] PER_LOAD  = TIMER_W'(POLL_PERIOD_US);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [2:0]  retry_q;
    logic [7:0]  lsb_q;
    logic [11:0] temp_q;
    logic        err_q;

    logic conv_zero, per_zero;
    logic conv_load, per_load;
    logic rsp_take, retry_inc, exhaust, enter_rst;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_ISSUE;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        retry_inc = 1'b0;
        exhaust   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start || (auto_en && per_zero)) begin
                    state_d = ST_RST1;
                    phase_d = PH_ISSUE;
                end
            end
            ST_WAITC: begin
                if (conv_zero) begin
                    state_d = ST_RST2;
                    phase_d = PH_ISSUE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (phase_q == PH_ISSUE) begin
                    if (eng_cmd_ready) phase_d = PH_AWAIT;
                end else if (eng_rsp_valid) begin
                    phase_d = PH_ISSUE;
                    // A missing presence pulse reissues the same RESET.
                    if (is_reset_step(state_q) && !eng_rsp_presence) begin
                        if (retry_q == RETRY_LIM) begin
                            exhaust = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            retry_inc = 1'b1;
                        end
                    end else begin
                        state_d = next_step(state_q);
                    end
                end
            end
        endcase
    end

    assign rsp_take  = is_cmd_step(state_q) && (phase_q == PH_AWAIT)
                     && eng_rsp_valid;
    assign enter_rst = (state_d != state_q) && is_reset_step(state_d);
    assign conv_load = (state_q == ST_CONV) && (state_d == ST_WAITC);
    assign per_load  = (state_q == ST_IDLE) && (state_d == ST_RST1);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            retry_q <= '0;
            lsb_q   <= '0;
            temp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= exhaust;
            if (enter_rst) begin
                retry_q <= '0;
            end else if (retry_inc) begin
                retry_q <= retry_q + 3'd1;
            end
            if (rsp_take && state_q == ST_RDLO) begin
                lsb_q <= eng_rsp_data;
            end
            // Loaded on entry to DONE so temp_valid sees the new value.
            if (rsp_take && state_q == ST_RDHI) begin
                temp_q <= {eng_rsp_data[3:0], lsb_q};
            end
        end
    end

    always_comb begin
        eng_cmd_valid = 1'b0;
        eng_cmd_op    = 2'd0;
        eng_cmd_data  = 8'h00;
        if (is_cmd_step(state_q) && phase_q == PH_ISSUE) begin
            eng_cmd_valid = 1'b1;
            {eng_cmd_op, eng_cmd_data} = step_cmd(state_q);
        end
        busy           = (state_q != ST_IDLE);
        temp_valid     = (state_q == ST_DONE);
        temp_data      = temp_q;
        err_nopresence = err_q;
    end

    us_down_timer u_conv_timer (
        .clk      (clk),
        .nReset   (nReset),
        .en       (clk_en),
        .load     (conv_load),
        .load_val (CONV_LOAD),
        .zero     (conv_zero)
    );

    us_down_timer u_period_timer (
        .clk      (clk),
        .nReset   (nReset),
        .en       (clk_en),
        .load     (per_load),
        .load_val (PER_LOAD),
        .zero     (per_zero)
    );

endmodule

// File: tb/tb_temp_poll_scheduler.sv
// Directed bench: a shared byte-engine model serves either the manual
// instance (CONV_WAIT 10) or the auto-poll instance (CONV_WAIT 5).
module tb_temp_poll_scheduler;

    typedef struct {
        logic [7:0]  lsb;
        logic [7:0]  msb;
        int          fails;
        int          rst1;
        int          tv;
        int          err;
        logic [11:0] temp;
    } vec_t;

    logic clk, nReset, clk_en;
    logic start_m, start_a, auto_en_m, auto_en_a, sel;
    logic eng_ready, eng_rsp_valid, eng_rsp_pres;
    logic [7:0] eng_rsp_data;

    logic        m_cmd_valid, a_cmd_valid;
    logic [1:0]  m_cmd_op, a_cmd_op;
    logic [7:0]  m_cmd_data, a_cmd_data;
    logic [11:0] m_temp, a_temp;
    logic        m_tv, a_tv, m_busy, a_busy, m_err, a_err;
    logic        m_ready, m_rsp_valid, a_ready, a_rsp_valid;
    logic        cv, s_busy, s_tv, s_err;
    logic [1:0]  cop;
    logic [7:0]  cdat;

    assign m_ready     = eng_ready & ~sel;
    assign m_rsp_valid = eng_rsp_valid & ~sel;
    assign a_ready     = eng_ready & sel;
    assign a_rsp_valid = eng_rsp_valid & sel;
    assign cv     = sel ? a_cmd_valid : m_cmd_valid;
    assign cop    = sel ? a_cmd_op : m_cmd_op;
    assign cdat   = sel ? a_cmd_data : m_cmd_data;
    assign s_busy = sel ? a_busy : m_busy;
    assign s_tv   = sel ? a_tv : m_tv;
    assign s_err  = sel ? a_err : m_err;

    temp_poll_scheduler #(
        .CONV_WAIT_US(10), .POLL_PERIOD_US(50), .MAX_RETRY(3)
    ) u_main (
        .clk(clk), .nReset(nReset), .clk_en(clk_en),
        .start(start_m), .auto_en(auto_en_m),
        .eng_cmd_valid(m_cmd_valid), .eng_cmd_op(m_cmd_op),
        .eng_cmd_data(m_cmd_data), .eng_cmd_ready(m_ready),
        .eng_rsp_valid(m_rsp_valid), .eng_rsp_data(eng_rsp_data),
        .eng_rsp_presence(eng_rsp_pres),
        .temp_data(m_temp), .temp_valid(m_tv),
        .busy(m_busy), .err_nopresence(m_err)
    );

    temp_poll_scheduler #(
        .CONV_WAIT_US(5), .POLL_PERIOD_US(50), .MAX_RETRY(3)
    ) u_auto (
        .clk(clk), .nReset(nReset), .clk_en(clk_en),
        .start(start_a), .auto_en(auto_en_a),
        .eng_cmd_valid(a_cmd_valid), .eng_cmd_op(a_cmd_op),
        .eng_cmd_data(a_cmd_data), .eng_cmd_ready(a_ready),
        .eng_rsp_valid(a_rsp_valid), .eng_rsp_data(eng_rsp_data),
        .eng_rsp_presence(eng_rsp_pres),
        .temp_data(a_temp), .temp_valid(a_tv),
        .busy(a_busy), .err_nopresence(a_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine model state (written only by the engine process)
    int         e_st, log_n, rst_count, cyc, tick_total, tick_ph;
    int         t_conv_rsp, t_rst_acc;
    logic [9:0] log_cmd [1024];
    logic [1:0] cur_op;
    logic [7:0] cur_data;
    bit         rd_lsb;
    // Engine controls (written only by the main process)
    int         fail_until;
    logic [7:0] lsb_v, msb_v;
    bit         stall_read;

    initial begin
        e_st = 0; log_n = 0; rst_count = 0; cyc = 0;
        tick_total = 0; tick_ph = 0; rd_lsb = 0;
        t_conv_rsp = 0; t_rst_acc = 0;
        cur_op = 2'd0; cur_data = 8'h00;
        clk_en = 0; eng_ready = 0; eng_rsp_valid = 0;
        eng_rsp_pres = 0; eng_rsp_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tick_ph = (tick_ph + 1) % 4;
            clk_en = (tick_ph == 0);
            if (clk_en) tick_total++;
            eng_ready = 0;
            eng_rsp_valid = 0;
            eng_rsp_pres = 0;
            eng_rsp_data = 8'h00;
            if (!nReset) begin
                e_st = 0;
                rd_lsb = 0;
            end else begin
                case (e_st)
                    0: if (cv) e_st = 1;
                    1: begin
                        if (cv) begin
                            eng_ready = 1;
                            cur_op = cop;
                            cur_data = cdat;
                            if (log_n < 1024) log_cmd[log_n] = {cop, cdat};
                            log_n++;
                            if (cop == 2'd0) t_rst_acc = cyc;
                            e_st = 2;
                        end else begin
                            e_st = 0;
                        end
                    end
                    2: begin
                        if (cur_op == 2'd2 && stall_read) begin
                            e_st = 4;
                        end else begin
                            eng_rsp_valid = 1;
                            if (cur_op == 2'd0) begin
                                eng_rsp_pres = (rst_count >= fail_until);
                                rst_count++;
                            end else if (cur_op == 2'd2) begin
                                eng_rsp_data = rd_lsb ? lsb_v : msb_v;
                                rd_lsb = 0;
                            end else begin
                                if (cur_data == 8'hBE) rd_lsb = 1;
                                if (cur_data == 8'h44) t_conv_rsp = cyc;
                            end
                            e_st = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    int n_tv, n_err, n_rise;
    int rise_tick [64];
    logic prev_busy;

    initial begin
        n_tv = 0; n_err = 0; n_rise = 0; prev_busy = 0;
        forever begin
            @(negedge clk);
            if (s_tv) n_tv++;
            if (s_err) n_err++;
            if (s_busy && !prev_busy) begin
                if (n_rise < 64) rise_tick[n_rise] = tick_total - int'(clk_en);
                n_rise++;
            end
            prev_busy = s_busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1);
    end

    int n_vec, n_fail;
    vec_t vt [6];
    logic [9:0] exp_seq [8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act,
                               input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        nReset = 0;
        repeat (3) @(negedge clk);
        nReset = 1;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base, tv0, err0, cnt;
        base = log_n;
        tv0 = n_tv;
        err0 = n_err;
        fail_until = rst_count + v.fails;
        lsb_v = v.lsb;
        msb_v = v.msb;
        @(negedge clk);
        start_m = 1;
        @(negedge clk);
        start_m = 0;
        for (int n = 0; n < 3000 && s_busy; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        check({tag, "_idle"}, int'(s_busy), 0);
        cnt = 0;
        while (base + cnt < log_n && log_cmd[base + cnt][9:8] == 2'd0) cnt++;
        check({tag, "_rst1_count"}, cnt, v.rst1);
        check({tag, "_cmd_count"}, log_n - base,
              (v.err != 0) ? v.rst1 : v.rst1 + 7);
        check({tag, "_temp_valid"}, n_tv - tv0, v.tv);
        check({tag, "_err"}, n_err - err0, v.err);
        check({tag, "_temp"}, int'(m_temp), int'(v.temp));
        if (v.err == 0) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("%s_cmd%0d", tag, i),
                      int'(log_cmd[base + v.rst1 - 1 + i]), int'(exp_seq[i]));
            end
        end
    endtask

    initial begin
        int r0, tv0, first, diff;
        n_vec = 0; n_fail = 0;
        start_m = 0; start_a = 0; auto_en_m = 0; auto_en_a = 0;
        sel = 0; stall_read = 0; fail_until = 0;
        lsb_v = 8'h00; msb_v = 8'h00;
        exp_seq[0] = {2'd0, 8'h00};
        exp_seq[1] = {2'd1, 8'hCC};
        exp_seq[2] = {2'd1, 8'h44};
        exp_seq[3] = {2'd0, 8'h00};
        exp_seq[4] = {2'd1, 8'hCC};
        exp_seq[5] = {2'd1, 8'hBE};
        exp_seq[6] = {2'd2, 8'h00};
        exp_seq[7] = {2'd2, 8'h00};
        vt[0] = '{8'h91, 8'h01, 0, 1, 1, 0, 12'h191};
        vt[1] = '{8'h00, 8'h00, 0, 1, 1, 0, 12'h000};
        vt[2] = '{8'h50, 8'h05, 2, 3, 1, 0, 12'h550};
        vt[3] = '{8'h12, 8'h34, 99, 4, 0, 1, 12'h550};
        vt[4] = '{8'hFF, 8'hFF, 3, 4, 1, 0, 12'hFFF};
        vt[5] = '{8'hAA, 8'hBB, 4, 4, 0, 1, 12'hFFF};

        nReset = 1;
        #1 nReset = 0;
        repeat (3) @(negedge clk);
        check("rst_cmd_valid", int'(m_cmd_valid), 0);
        check("rst_cmd_op", int'(m_cmd_op), 0);
        check("rst_cmd_data", int'(m_cmd_data), 0);
        check("rst_temp", int'(m_temp), 0);
        check("rst_temp_valid", int'(m_tv), 0);
        check("rst_busy", int'(m_busy), 0);
        check("rst_err", int'(m_err), 0);
        nReset = 1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        run_vec(vt[0], "conv");
        diff = t_rst_acc - t_conv_rsp;
        check_range("conv_wait_cycles", diff, 40, 44);

        stall_read = 1;
        fail_until = rst_count;
        lsb_v = 8'h33;
        msb_v = 8'h02;
        @(negedge clk);
        start_m = 1;
        @(negedge clk);
        start_m = 0;
        for (int n = 0; n < 3000 && e_st != 4; n++) @(negedge clk);
        check("rdlo_await_reached", e_st, 4);
        @(negedge clk);
        #2 nReset = 0;
        #1;
        check("midrst_cmd_valid", int'(m_cmd_valid), 0);
        check("midrst_busy", int'(m_busy), 0);
        check("midrst_temp", int'(m_temp), 0);
        repeat (2) @(negedge clk);
        stall_read = 0;
        nReset = 1;
        repeat (2) @(negedge clk);
        run_vec(vt[0], "post_rst");

        sel = 1;
        fail_until = 0;
        lsb_v = 8'hA7;
        msb_v = 8'h02;
        reset_pulse();
        r0 = n_rise;
        tv0 = n_tv;
        first = -1;
        auto_en_a = 1;
        for (int n = 0; n < 4000 && n_rise < r0 + 4; n++) begin
            @(negedge clk);
            if (first < 0 && n_rise > r0) first = n;
            start_a = (n_rise == r0 + 2) && a_busy && (n % 9 == 0);
        end
        start_a = 0;
        check_range("auto_first_delay", first, 0, 2);
        check("auto_poll_count", n_rise - r0, 4);
        check("auto_temp_valid", n_tv - tv0, 3);
        check("auto_temp", int'(a_temp), 12'h2A7);
        if (r0 + 3 < 64) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("auto_gap%0d_ticks", k),
                      rise_tick[r0 + k + 1] - rise_tick[r0 + k], 50);
            end
        end
        auto_en_a = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/temp_poll_scheduler.md
TEMP_POLL_SCHEDULER -- requirements
Module: temp_poll_scheduler

Interface
REQ-001 Parameter CONV_WAIT_US, default 750000: conversion wait in clk_en ticks; legal range 1..2^20-1.
REQ-002 Parameter POLL_PERIOD_US, default 1000000: auto-poll interval in clk_en ticks, start-to-start; legal range 1..2^20-1.
REQ-003 Parameter MAX_RETRY, default 3: presence-failure retries per reset step; legal range 0..7.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 nReset  input  1  reset, asynchronous, active-low.
REQ-006 clk_en  input  1  1 us tick strobe; gates timers only.
REQ-007 start  input  1  single-cycle manual poll request.
REQ-008 auto_en  input  1  enables periodic polling.
REQ-009 eng_cmd_valid  output  1  command to 1-Wire byte engine valid.
REQ-010 eng_cmd_op  output  2  command opcode: RESET, WRITE, READ.
REQ-011 eng_cmd_data  output  8  byte for WRITE; 0 otherwise.
REQ-012 eng_cmd_ready  input  1  engine accepts command.
REQ-013 eng_rsp_valid  input  1  single-cycle command completion.
REQ-014 eng_rsp_data  input  8  byte returned by READ.
REQ-015 eng_rsp_presence  input  1  presence pulse seen; meaningful for RESET only.
REQ-016 temp_data  output  12  last good reading, {MSB[3:0], LSB[7:0]}.
REQ-017 temp_valid  output  1  one-cycle pulse when temp_data updates.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 err_nopresence  output  1  one-cycle pulse when retries are exhausted.

Function
REQ-020 FSM states: IDLE, RST1, SKIP1, CONV, WAITC, RST2, SKIP2, RDSP, RDLO, RDHI, DONE.
REQ-021 Command steps RST1/SKIP1/CONV/RST2/SKIP2/RDSP/RDLO/RDHI have two phases: ISSUE (eng_cmd_valid=1 until the cycle eng_cmd_ready=1), then AWAIT (eng_cmd_valid=0 until eng_rsp_valid).
REQ-022 At most one command outstanding; eng_cmd_op/eng_cmd_data stable while eng_cmd_valid=1.
REQ-023 Step commands: RST1/RST2=RESET; SKIP1/SKIP2=WRITE 0xCC; CONV=WRITE 0x44; RDSP=WRITE 0xBE; RDLO/RDHI=READ.
REQ-024 IDLE->RST1 on start=1, or on auto_en=1 with period timer expired; coincident start and expiry produce one poll.
REQ-025 start while busy=1 is ignored, not queued.
REQ-026 RESET response with eng_rsp_presence=0: retry counter increments and the same RESET reissues; after MAX_RETRY retries fail, err_nopresence pulses and FSM goes to IDLE, temp_data unchanged.
REQ-027 Retry counter clears on entry to RST1 and to RST2.
REQ-028 WAITC loads CONV_WAIT_US on entry, decrements on clk_en, exits to RST2 the cycle after it reaches 0.
REQ-029 RDLO response latches LSB; RDHI response latches MSB.
REQ-030 DONE lasts one cycle: temp_data={MSB[3:0],LSB}, temp_valid=1, next state IDLE.
REQ-031 Period timer reloads POLL_PERIOD_US at every IDLE->RST1 transition, decrements on clk_en, saturates at 0.
REQ-032 auto_en=0 leaves the period timer running but blocks auto starts.
REQ-033 A response arriving in the same cycle as acceptance is not possible by engine contract; an unexpected eng_rsp_valid in ISSUE or IDLE is ignored.
REQ-034 Latency: poll with instant engine = 16 + CONV_WAIT_US/clk_en-rate cycles, no retries.

Reset
REQ-035 On nReset=0, all outputs are 0, the FSM goes to IDLE, and the counters clear. The period timer loads 0 so that the first auto poll starts as soon as auto_en=1.
REQ-036 Reset asserted mid-command drops eng_cmd_valid asynchronously. The engine is reset by the same nReset.

Structure
REQ-037 Package onewire_pkg holds: opcode encodings (RESET=0, WRITE=1, READ=2); ROM/function bytes 0xCC, 0x44, 0xBE; FSM state type.
REQ-038 One sub-module, us_down_timer (20-bit load/decrement-on-enable/zero flag), is instantiated twice: conversion timer and period timer.

Verification
REQ-039 Bench must cover manual poll: start pulse, engine model returns presence=1, LSB=0x91, MSB=0x01. Required: command sequence RESET, CC, 44, RESET, CC, BE, READ, READ; then temp_data=0x191 and one temp_valid pulse.
REQ-040 Bench must cover retry exhaustion: presence=0 always, MAX_RETRY=3. Required: exactly 4 RESET commands, one err_nopresence pulse, temp_data unchanged, busy=0.
REQ-041 Bench must cover recovery: presence=0 twice, then 1. Required: 3 RESET commands, poll completes, no err pulse.
REQ-042 Bench must cover the conversion wait: CONV_WAIT_US=10, clk_en every 4th cycle. Required: second RESET issued 40-44 cycles after the CONV response.
REQ-043 Bench must cover auto mode: auto_en=1, POLL_PERIOD_US=50, CONV_WAIT_US=5. Required: successive RST1 entries exactly 50 clk_en ticks apart; start pulses while busy produce no extra poll.
REQ-044 Bench must cover mid-operation reset: nReset asserted during RDLO AWAIT. Required: eng_cmd_valid=0, busy=0, temp_data=0 immediately; the next poll completes normally.
